// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package inst_loader_pkg;

  // FSM state encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_LEN_HI = S_LEN_HI,
    ST_LEN_LO = S_LEN_LO,
    ST_DATA   = S_DATA,
    ST_CSUM   = S_CSUM,
    ST_DONE   = S_DONE,
    ST_ERROR  = S_ERROR
  } state_t;

  // Frame field constants
  localparam int unsigned HDR_BYTES      = 2;  // LEN_HI, LEN_LO
  localparam int unsigned BYTES_PER_WORD = 4;  // big-endian instruction word

endpackage

// File: rtl/inst_loader_word_assembler.sv
// Packs four consecutive stream bytes (MSB first) into a 32-bit word.
// Latency: word_valid pulses one cycle after the 4th byte is accepted.
// Backpressure: none; the parent only asserts byte_en on an accepted byte.
//
// Ports:
//   clock, reset    - clock and synchronous active-high reset
//   clear           - restart at byte 0 of a word (start of a new load)
//   byte_en/byte_in - one accepted stream byte
//   last_byte       - the next accepted byte completes a word
//   word_valid/word - registered assembled word, valid for one cycle
module inst_loader_word_assembler
  import inst_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [23:0] shreg;

  assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt   <= 2'd0;
      shreg      <= 24'd0;
      word_valid <= 1'b0;
      word       <= 32'd0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_cnt <= 2'd0;
        shreg    <= 24'd0;
      end else if (byte_en) begin
        shreg    <= {shreg[15:0], byte_in};
        // 2-bit counter wraps 3 -> 0 on its own at the word boundary
        byte_cnt <= byte_cnt + 2'd1;
        if (last_byte) begin
          word_valid <= 1'b1;
          word       <= {shreg, byte_in};
        end
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot loader: parses LEN_HI, LEN_LO, 4*N payload bytes, CSUM and writes instruction memory.
// Latency: memory write one cycle after a word's 4th byte; done/error one cycle after CSUM.
// Backpressure: byte_ready is high in every streaming state, so one byte per clock is sustained.
//
// Ports:
//   clock, reset                  - clock and synchronous active-high reset
//   load_start                    - begin a load (only from IDLE, DONE or ERROR)
//   byte_valid/byte_data/byte_ready - framed byte stream
//   mem_we/mem_addr/mem_wdata     - instruction memory write port (byte address)
//   cpu_reset, done, error        - load status; CPU held in reset until a good load
//   words_loaded                  - words written by the current or last load
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
)
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int LW = 8 * HDR_BYTES;  // length field width
  localparam logic [LW:0]         MAX_WORDS = (LW + 1)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH + 1)'(1);

  state_t state, state_nxt;

  logic [7:0]          len_hi;
  logic [7:0]          csum;
  logic [ADDR_WIDTH:0] words_left;  // words still to be assembled
  logic [LW-1:0]       len_word;
  logic [LW:0]         len_ext;
  logic                start;
  logic                data_xfer;
  logic                asm_last;
  logic                asm_vld;
  logic [31:0]         asm_word;

  assign len_word  = {len_hi, byte_data};
  assign len_ext   = {1'b0, len_word};
  assign data_xfer = byte_valid && (state == ST_DATA);

  inst_loader_word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (start),
    .byte_en    (data_xfer),
    .byte_in    (byte_data),
    .last_byte  (asm_last),
    .word_valid (asm_vld),
    .word       (asm_word)
  );

  // The write address is the pre-increment word index; words_loaded
  // advances at the end of the write cycle.
  assign mem_we    = asm_vld;
  assign mem_wdata = asm_word;
  assign mem_addr  = 32'(words_loaded[ADDR_WIDTH-1:0]) * BYTES_PER_WORD;

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    start      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (load_start) begin
          start     = 1'b1;
          state_nxt = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (len_ext > MAX_WORDS)    state_nxt = ST_ERROR;
          else if (len_word == '0)    state_nxt = ST_CSUM;
          else                        state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        byte_ready = 1'b1;
        if (byte_valid && asm_last && (words_left == ONE)) state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = (byte_data == csum) ? ST_DONE : ST_ERROR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      len_hi       <= 8'd0;
      csum         <= 8'd0;
      words_left   <= '0;
      words_loaded <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state <= state_nxt;

      if (start) begin
        csum         <= 8'd0;
        words_loaded <= '0;
        done         <= 1'b0;
        error        <= 1'b0;
        cpu_reset    <= 1'b1;
      end

      if (state == ST_LEN_HI && byte_valid) len_hi <= byte_data;
      if (state == ST_LEN_LO && byte_valid) words_left <= len_word[ADDR_WIDTH:0];

      if (data_xfer) begin
        csum <= csum ^ byte_data;
        if (asm_last) words_left <= words_left - ONE;
      end

      if (asm_vld) words_loaded <= words_loaded + ONE;

      // Status flags are raised on entry into the terminal states.
      if (state != ST_DONE && state_nxt == ST_DONE) begin
        done      <= 1'b1;
        cpu_reset <= 1'b0;
      end
      if (state != ST_ERROR && state_nxt == ST_ERROR) error <= 1'b1;
    end
  end

endmodule
